// File: rtl/ipml_prefetch_fifo_sc_v2_0.sv
// rtl/ipml_prefetch_fifo_sc_v2_0.sv - single-clock FWFT FIFO with RAM plus 2-entry prefetch stage
// Level, almost flags, flush, sticky overflow and high-water mark are all registered.
module ipml_prefetch_fifo_sc_v2_0 #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 9,
   parameter int AF_LEVEL = 2**ADDR_W - 4,
   parameter int AE_LEVEL = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic                wr_en,
   output logic                wr_vld,
   output logic [DATA_W-1:0]   rd_data,
   input  logic                rd_en,
   output logic                rd_vld,
   input  logic                flush,
   output logic [ADDR_W:0]     level,
   output logic                almost_full,
   output logic                almost_empty,
   output logic                overflow,
   output logic [ADDR_W:0]     hiwater
);

   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
   localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);

   typedef enum logic [1:0] {S0, S1, S2} state_t;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] ram_q;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   ram_cnt;
   logic              inflight;
   state_t            state;
   logic [DATA_W-1:0] st0;
   logic [DATA_W-1:0] st1;
   logic              rd_vld_q;
   logic [1:0]        stage_cnt;
   logic [2:0]        stage_proj;
   logic              wr_acc;
   logic              pop;
   logic              rd_issue;
   logic [ADDR_W:0]   next_level;

   // wr_vld depends only on the registered RAM count, never on rd_en
   assign wr_vld   = (ram_cnt != DEPTH_C);
   assign rd_vld   = rd_vld_q;
   assign rd_data  = st0;
   assign wr_acc   = wr_en & wr_vld & ~flush;
   assign pop      = rd_vld_q & rd_en & ~flush;

   always_comb begin
      stage_cnt = 2'd0;
      case (state)
         S0:      stage_cnt = 2'd0;
         S1:      stage_cnt = 2'd1;
         default: stage_cnt = 2'd2;
      endcase
   end

   // Occupancy of the stage once the current arrival and pop have settled
   assign stage_proj = {1'b0, stage_cnt} + {2'b00, inflight} - {2'b00, pop};
   assign rd_issue   = ~flush & (ram_cnt != '0) & (stage_proj < 3'd2);

   always_comb begin
      next_level = level;
      if (flush)
         next_level = '0;
      else if (wr_acc & ~pop)
         next_level = level + 1'b1;
      else if (pop & ~wr_acc)
         next_level = level - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (wr_acc)
         mem[wr_ptr] <= wr_data;
      if (rd_issue)
         ram_q <= mem[rd_ptr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         ram_cnt  <= '0;
         inflight <= 1'b0;
      end else if (flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         ram_cnt  <= '0;
         inflight <= 1'b0;
      end else begin
         if (wr_acc)
            wr_ptr <= wr_ptr + 1'b1;
         if (rd_issue)
            rd_ptr <= rd_ptr + 1'b1;
         ram_cnt  <= ram_cnt + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_issue);
         inflight <= rd_issue;
      end
   end

   // Stage FSM: inflight marks RAM data arriving at this edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S0;
         st0      <= '0;
         st1      <= '0;
         rd_vld_q <= 1'b0;
      end else if (flush) begin
         state    <= S0;
         rd_vld_q <= 1'b0;
      end else begin
         case (state)
            S0: begin
               if (inflight) begin
                  st0      <= ram_q;
                  state    <= S1;
                  rd_vld_q <= 1'b1;
               end
            end
            S1: begin
               if (inflight && pop) begin
                  st0 <= ram_q;
               end else if (inflight) begin
                  st1   <= ram_q;
                  state <= S2;
               end else if (pop) begin
                  state    <= S0;
                  rd_vld_q <= 1'b0;
               end
            end
            default: begin
               if (pop && inflight) begin
                  st0 <= st1;
                  st1 <= ram_q;
               end else if (pop) begin
                  st0   <= st1;
                  state <= S1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level        <= '0;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         hiwater      <= '0;
      end else begin
         level        <= next_level;
         almost_full  <= (next_level >= AF_C);
         almost_empty <= (next_level <= AE_C);
         if (flush)
            overflow <= 1'b0;
         else if (wr_en & ~wr_vld)
            overflow <= 1'b1;
         if (flush)
            hiwater <= '0;
         else if (next_level > hiwater)
            hiwater <= next_level;
      end
   end

endmodule

// File: tb/tb_ipml_prefetch_fifo_sc_v2_0.sv
// tb/tb_ipml_prefetch_fifo_sc_v2_0.sv - randomized bench with queue-based reference model
module tb_ipml_prefetch_fifo_sc_v2_0;

   localparam int DW = 32;
   localparam int AW = 2;
   localparam int DEPTH = 4;
   localparam int CAP = DEPTH + 2;
   localparam int AF = 5;
   localparam int AE = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_en = 1'b0;
   logic          wr_vld;
   logic [DW-1:0] rd_data;
   logic          rd_en = 1'b0;
   logic          rd_vld;
   logic          flush = 1'b0;
   logic [AW:0]   level;
   logic          almost_full;
   logic          almost_empty;
   logic          overflow;
   logic [AW:0]   hiwater;

   int n_chk = 0;
   int n_fail = 0;
   bit chk_on = 1'b0;

   logic [DW-1:0] mq[$];
   int  m_vis = 0;
   int  m_pend = 0;
   int  m_hw = 0;
   bit  m_ovf = 1'b0;

   ipml_prefetch_fifo_sc_v2_0 #(
      .DATA_W(DW), .ADDR_W(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)
   ) dut (
      .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en), .wr_vld(wr_vld),
      .rd_data(rd_data), .rd_en(rd_en), .rd_vld(rd_vld), .flush(flush), .level(level),
      .almost_full(almost_full), .almost_empty(almost_empty), .overflow(overflow),
      .hiwater(hiwater)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_vis = 0;
      m_pend = 0;
      m_hw = 0;
      m_ovf = 1'b0;
   endtask

   // Words leave the RAM one per cycle into at most two prefetch slots and become visible a cycle later
   task automatic model_edge(input bit we, input bit re, input bit fl, input logic [DW-1:0] wd);
      int ram;
      bit pop, acc, issue;
      if (fl) begin
         model_reset();
         return;
      end
      pop   = (m_vis > 0) && re;
      ram   = mq.size() - m_vis - m_pend;
      acc   = we && (ram != DEPTH);
      if (we && !acc)
         m_ovf = 1'b1;
      issue = (ram > 0) && ((m_vis + m_pend - int'(pop)) < 2);
      if (pop)
         void'(mq.pop_front());
      if (acc)
         mq.push_back(wd);
      m_vis  = m_vis + m_pend - int'(pop);
      m_pend = int'(issue);
      if (mq.size() > m_hw)
         m_hw = mq.size();
   endtask

   task automatic cycle(input bit we, input logic [DW-1:0] wd, input bit re, input bit fl);
      wr_en   = we;
      wr_data = wd;
      rd_en   = re;
      flush   = fl;
      @(posedge clk);
      model_edge(we, re, fl, wd);
      #1;
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         chk("level", 64'(level), 64'(mq.size()));
         chk("rd_vld", 64'(rd_vld), 64'(m_vis > 0));
         if (m_vis > 0)
            chk("rd_data", 64'(rd_data), 64'(mq[0]));
         chk("wr_vld", 64'(wr_vld), 64'((mq.size() - m_vis - m_pend) != DEPTH));
         chk("almost_full", 64'(almost_full), 64'(mq.size() >= AF));
         chk("almost_empty", 64'(almost_empty), 64'(mq.size() <= AE));
         chk("overflow", 64'(overflow), 64'(m_ovf));
         chk("hiwater", 64'(hiwater), 64'(m_hw));
      end
   end

   initial begin
      int rdp;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wr_vld", 64'(wr_vld), 64'd1);
      chk("rst_rd_vld", 64'(rd_vld), 64'd0);
      chk("rst_rd_data", 64'(rd_data), 64'd0);
      chk("rst_level", 64'(level), 64'd0);
      chk("rst_ae", 64'(almost_empty), 64'd1);
      chk("rst_af", 64'(almost_full), 64'd0);
      rst_n = 1'b1;
      chk_on = 1'b1;
      cycle(0, '0, 0, 0);

      // single word latency
      cycle(1, 32'hA5A5A5A5, 0, 0);
      chk("lat_level_E", 64'(level), 64'd1);
      chk("lat_vld_E", 64'(rd_vld), 64'd0);
      cycle(0, '0, 0, 0);
      chk("lat_vld_E1", 64'(rd_vld), 64'd0);
      cycle(0, '0, 0, 0);
      chk("lat_vld_E2", 64'(rd_vld), 64'd1);
      chk("lat_data_E2", 64'(rd_data), 64'hA5A5A5A5);
      cycle(0, '0, 1, 0);
      chk("lat_drained", 64'(level), 64'd0);

      // fill to capacity and overflow
      for (int i = 0; i < CAP; i++)
         cycle(1, 32'h100 + i, 0, 0);
      chk("full_level", 64'(level), 64'(CAP));
      chk("full_wr_vld", 64'(wr_vld), 64'd0);
      cycle(1, 32'hDEAD, 0, 0);
      chk("ovf_set", 64'(overflow), 64'd1);
      chk("ovf_level", 64'(level), 64'(CAP));
      chk("ovf_hiwater", 64'(hiwater), 64'(CAP));

      // flush with write and read requested in the same cycle
      cycle(1, 32'hBEEF, 1, 1);
      chk("fl_level", 64'(level), 64'd0);
      chk("fl_rd_vld", 64'(rd_vld), 64'd0);
      chk("fl_ovf", 64'(overflow), 64'd0);
      chk("fl_hiwater", 64'(hiwater), 64'd0);
      cycle(1, 32'h77, 0, 0);
      cycle(0, '0, 0, 0);
      chk("fl_next_vld1", 64'(rd_vld), 64'd0);
      cycle(0, '0, 0, 0);
      chk("fl_next_vld2", 64'(rd_vld), 64'd1);
      chk("fl_next_data", 64'(rd_data), 64'h77);
      cycle(0, '0, 1, 0);

      // streaming: one write and one pop per cycle
      for (int i = 1; i <= 20; i++) begin
         cycle(1, 32'h2000 + i, 1, 0);
         if (i >= 3) begin
            chk("stream_vld", 64'(rd_vld), 64'd1);
            chk("stream_level", 64'(level == 2 || level == 3), 64'd1);
         end
      end
      for (int i = 0; i < 4; i++)
         cycle(0, '0, 1, 0);
      chk("stream_empty", 64'(level), 64'd0);

      // almost flags step up then down
      for (int k = 1; k <= CAP; k++) begin
         cycle(1, 32'h300 + k, 0, 0);
         chk("af_up", 64'(almost_full), 64'(k >= 5));
         chk("ae_up", 64'(almost_empty), 64'(k <= 2));
      end
      cycle(0, '0, 0, 0);
      cycle(0, '0, 0, 0);
      for (int k = CAP - 1; k >= 0; k--) begin
         cycle(0, '0, 1, 0);
         chk("dn_level", 64'(level), 64'(k));
         chk("af_dn", 64'(almost_full), 64'(k >= 5));
         chk("ae_dn", 64'(almost_empty), 64'(k <= 2));
      end

      // randomized traffic with varying consumer rate, rare flush, one async reset
      for (int seg = 0; seg < 4; seg++) begin
         rdp = (seg == 0) ? 20 : (seg == 1) ? 50 : (seg == 2) ? 80 : 100;
         for (int i = 0; i < 600; i++) begin
            cycle(($urandom % 4) != 0, $urandom, ($urandom % 100) < rdp,
                  ($urandom % 150) == 0);
            if (seg == 2 && i == 300) begin
               chk_on = 1'b0;
               #1 rst_n = 1'b0;
               #1;
               chk("arst_rd_vld", 64'(rd_vld), 64'd0);
               chk("arst_level", 64'(level), 64'd0);
               chk("arst_wr_vld", 64'(wr_vld), 64'd1);
               chk("arst_rd_data", 64'(rd_data), 64'd0);
               model_reset();
               wr_en = 1'b0;
               rd_en = 1'b0;
               flush = 1'b0;
               @(posedge clk);
               #1 rst_n = 1'b1;
               chk_on = 1'b1;
            end
         end
      end

      chk_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
